// File: rtl/spi_dac_rx.sv
// Receive end of the 3-wire LE/CLK/DATA DAC link: synchronises the link lines,
// deserialises MSB-first frames and offers each good frame on a valid/ack port.
//
// state | meaning
// HUNT  | after reset, wait for a trustworthy LE-low before arming
// ARM   | LE low between frames, wait for LE rise to start a clean frame
// SHIFT | LE high, shift one bit per serial clock rise
// LATCH | one cycle, accept the frame if it had exactly WIDTH bits
module spi_dac_rx #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spi_le,
  input  logic             spi_clk,
  input  logic             spi_dat,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  input  logic             sample_ack,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam logic [1:0] S_HUNT  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;
  localparam logic [3:0] FULL_CNT = 4'(WIDTH);

  logic [SYNC_STAGES-1:0] le_sync_q, clk_sync_q, dat_sync_q;
  logic                   le_dly_q, clk_dly_q;
  logic [SYNC_STAGES:0]   prime_q;
  logic [1:0]             state_q, state_d;
  logic [WIDTH-1:0]       shreg_q, shreg_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [WIDTH-1:0]       out_q, out_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   ovr_q, ovr_d;

  logic le_s, clk_s, dat_s, le_fall, le_rise, clk_rise;

  assign le_s     = le_sync_q[SYNC_STAGES-1];
  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign dat_s    = dat_sync_q[SYNC_STAGES-1];
  assign le_fall  = le_dly_q & ~le_s;
  assign le_rise  = ~le_dly_q & le_s;
  assign clk_rise = ~clk_dly_q & clk_s;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    if (sample_ack && valid_q) valid_d = 1'b0;
    case (state_q)
      // The reset zeros in the synchroniser look like LE low; only trust LE
      // once real pin samples have filled the whole chain.
      S_HUNT: if (prime_q[SYNC_STAGES] && !le_s) state_d = S_ARM;
      S_ARM: begin
        if (le_rise) begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (le_fall) begin
          state_d = S_LATCH;
        end else if (clk_rise && le_s) begin
          shreg_d = {shreg_q[WIDTH-2:0], dat_s};
          if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
        end
      end
      S_LATCH: begin
        if (cnt_q == FULL_CNT) begin
          out_d   = shreg_q;
          valid_d = 1'b1;
          ovr_d   = valid_q && !sample_ack;
        end else begin
          err_d = 1'b1;
        end
        state_d = S_ARM;
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      le_sync_q  <= '0;
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      le_dly_q   <= 1'b0;
      clk_dly_q  <= 1'b0;
      prime_q    <= '0;
      state_q    <= S_HUNT;
      shreg_q    <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      le_sync_q  <= {le_sync_q[SYNC_STAGES-2:0], spi_le};
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], spi_dat};
      le_dly_q   <= le_s;
      clk_dly_q  <= clk_s;
      prime_q    <= {prime_q[SYNC_STAGES-1:0], 1'b1};
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      ovr_q      <= ovr_d;
    end
  end

  assign sample_out   = out_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign overrun      = ovr_q;
  assign busy         = (state_q == S_SHIFT) && (cnt_q != 4'd0);

endmodule

// File: tb/tb_spi_dac_rx.sv
// Directed and random frames on the LE/CLK/DATA link, checked against a
// frame-level model of the expected sample, valid flag and pulse timing.
module tb_spi_dac_rx;
  localparam int WIDTH = 12;

  logic clk = 1'b0;
  logic rst, spi_le, spi_clk, spi_dat, sample_ack;
  logic [WIDTH-1:0] sample_out;
  logic sample_valid, frame_err, overrun, busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_out;
  bit exp_valid;

  always #5 clk = ~clk;

  spi_dac_rx #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi_le(spi_le), .spi_clk(spi_clk), .spi_dat(spi_dat),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ack(sample_ack),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    spi_dat = b;
    repeat (2) @(negedge clk);
    spi_clk = 1'b1;
    repeat (4) @(negedge clk);
    spi_clk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // seen=0: the receiver is expected to ignore this frame entirely
  task automatic end_frame(input int nbits, input logic [31:0] val, input bit ack_latch, input bit seen);
    logic [7:0] eh, oh;
    logic v3, v4;
    bit good, exp_ovr, old_valid;
    good      = seen && (nbits == WIDTH);
    old_valid = exp_valid;
    exp_ovr   = good && exp_valid && !ack_latch;
    spi_le = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      eh[i-1] = frame_err;
      oh[i-1] = overrun;
      if (i == 3) begin v3 = sample_valid; sample_ack = ack_latch; end
      if (i == 4) begin v4 = sample_valid; sample_ack = 1'b0; end
    end
    if (good) begin
      exp_out   = val[WIDTH-1:0];
      exp_valid = 1'b1;
    end else if (ack_latch && exp_valid) begin
      exp_valid = 1'b0;
    end
    check("err_pulse", {24'd0, eh}, (seen && !good) ? 32'h08 : 32'h00);
    check("ovr_pulse", {24'd0, oh}, exp_ovr ? 32'h08 : 32'h00);
    check("valid_pre", {31'd0, v3}, {31'd0, old_valid});
    check("valid_lat", {31'd0, v4}, {31'd0, exp_valid});
    check("sample_out", {20'd0, sample_out}, {20'd0, exp_out});
  endtask

  task automatic frame(input int nbits, input logic [31:0] val, input bit ack_latch);
    spi_le = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_idle", {31'd0, busy}, 32'd0);
    for (int k = nbits - 1; k >= 0; k--) begin
      send_bit(val[k]);
      if (k == nbits - 1) check("busy_shift", {31'd0, busy}, 32'd1);
    end
    end_frame(nbits, val, ack_latch, 1'b1);
  endtask

  task automatic ack_pulse();
    sample_ack = 1'b1;
    @(negedge clk);
    sample_ack = 1'b0;
    exp_valid = 1'b0;
    check("ack_valid", {31'd0, sample_valid}, 32'd0);
    check("ack_out", {20'd0, sample_out}, {20'd0, exp_out});
  endtask

  initial begin
    int lens [10];
    logic [31:0] v;
    lens = '{0, 5, 11, 12, 12, 12, 12, 13, 15, 17};
    rst = 1'b0; spi_le = 1'b0; spi_clk = 1'b0; spi_dat = 1'b0; sample_ack = 1'b0;
    exp_out = '0; exp_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_out", {20'd0, sample_out}, 32'd0);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    // good frame, ack, and ack with nothing pending
    frame(12, 32'hA5C, 1'b0);
    ack_pulse();
    ack_pulse();

    // short and long frames
    frame(11, 32'h5A5, 1'b0);
    frame(13, 32'h1ABC, 1'b0);

    // overrun
    frame(12, 32'h123, 1'b0);
    frame(12, 32'hFED, 1'b0);
    ack_pulse();

    // ack in the latch cycle of a new good frame
    frame(12, 32'h7FF, 1'b0);
    frame(12, 32'h800, 1'b1);

    // back-to-back LE pulses: zero-bit frame
    frame(0, 32'h0, 1'b0);

    // reset in the middle of a frame
    v = 32'h0C6;
    spi_le = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 11; k >= 6; k--) send_bit(v[k]);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_out", {20'd0, sample_out}, 32'd0);
    check("mid_rst_valid", {31'd0, sample_valid}, 32'd0);
    check("mid_rst_err", {31'd0, frame_err}, 32'd0);
    check("mid_rst_ovr", {31'd0, overrun}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    exp_out = '0; exp_valid = 1'b0;
    rst = 1'b1;
    for (int k = 5; k >= 0; k--) send_bit(v[k]);
    end_frame(12, v, 1'b0, 1'b0);
    frame(12, 32'h0F0, 1'b0);
    ack_pulse();

    // serial clocks while LE is low are ignored
    for (int k = 0; k < 4; k++) send_bit(k[0]);
    check("lelow_err", {31'd0, frame_err}, 32'd0);
    check("lelow_busy", {31'd0, busy}, 32'd0);
    frame(12, 32'h3C3, 1'b0);

    // random frames
    for (int n = 0; n < 16; n++) begin
      frame(lens[$urandom_range(0, 9)], $urandom, ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) ack_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
